// File: rtl/clock_time_core_pkg.sv
// Shared codes, field limits and wrap helpers for the clock timekeeping core.
// The FSM state encoding doubles as the Blink field-select code.
package clock_time_core_pkg;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_SEC  = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;
    localparam logic [1:0] BLINK_HOUR = 2'b11;

    typedef enum logic [1:0] {
        RUN      = BLINK_NONE,
        SET_SEC  = BLINK_SEC,
        SET_MIN  = BLINK_MIN,
        SET_HOUR = BLINK_HOUR
    } state_t;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    // Explicit compare-and-wrap keeps every field inside 0..max.
    function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] dec_wrap(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'd0 || v > max) ? max : v - 8'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low key.
// press pulses for one cycle on an accepted press; release produces nothing.
module key_debounce #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // Flip on the DEBOUNCE-th consecutive cycle the synchronized level disagrees.
    assign flip = (sync2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= flip && level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_time_core.sv
// Hours/minutes/seconds counter with key-driven time setting; feeds the
// seven-segment stage with binary fields and the field-under-edit code.
module clock_time_core
    import clock_time_core_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DEBOUNCE = 500_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        KEY_Mode_n,
    input  logic        KEY_Inc_n,
    input  logic        KEY_Dec_n,
    output logic [23:0] Number_Data,
    output logic [1:0]  Blink,
    output logic        Sec_Tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          mode_ev;
    logic          inc_ev;
    logic          dec_ev;
    logic          inc_only;
    logic          dec_only;
    logic          tick;
    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [7:0]    hour_q, min_q, sec_q;
    logic [7:0]    hour_d, min_d, sec_d;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_mode (
        .CLK(CLK), .RST(RST), .key_n(KEY_Mode_n), .press(mode_ev)
    );
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_inc (
        .CLK(CLK), .RST(RST), .key_n(KEY_Inc_n), .press(inc_ev)
    );
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_dec (
        .CLK(CLK), .RST(RST), .key_n(KEY_Dec_n), .press(dec_ev)
    );

    // Inc and Dec landing together cancel each other.
    assign inc_only = inc_ev && !dec_ev;
    assign dec_only = dec_ev && !inc_ev;
    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        if (mode_ev) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                default:  state_d = RUN;
            endcase
        end
    end

    // Field updates use the current state, so a same-cycle Mode event advances afterwards.
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        case (state_q)
            RUN: begin
                if (tick) begin
                    sec_d = inc_wrap(sec_q, SEC_MAX);
                    if (sec_q == SEC_MAX) begin
                        min_d = inc_wrap(min_q, MIN_MAX);
                        if (min_q == MIN_MAX) begin
                            hour_d = inc_wrap(hour_q, HOUR_MAX);
                        end
                    end
                end
            end
            SET_HOUR: begin
                if (inc_only)      hour_d = inc_wrap(hour_q, HOUR_MAX);
                else if (dec_only) hour_d = dec_wrap(hour_q, HOUR_MAX);
            end
            SET_MIN: begin
                if (inc_only)      min_d = inc_wrap(min_q, MIN_MAX);
                else if (dec_only) min_d = dec_wrap(min_q, MIN_MAX);
            end
            default: begin
                if (inc_only)      sec_d = inc_wrap(sec_q, SEC_MAX);
                else if (dec_only) sec_d = dec_wrap(sec_q, SEC_MAX);
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            presc_q  <= '0;
            Sec_Tick <= 1'b0;
            hour_q   <= 8'd0;
            min_q    <= 8'd0;
            sec_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            Sec_Tick <= tick;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            // Held at zero while setting so the first second back in RUN is full length.
            if (state_q != RUN || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign Number_Data[HOUR_LSB +: 8] = hour_q;
    assign Number_Data[MIN_LSB +: 8]  = min_q;
    assign Number_Data[SEC_LSB +: 8]  = sec_q;
    assign Blink = state_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core with TICK_DIV = 4 and DEBOUNCE = 3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clock_time_core;

    logic        CLK;
    logic        RST;
    logic        KEY_Mode_n;
    logic        KEY_Inc_n;
    logic        KEY_Dec_n;
    logic [23:0] Number_Data;
    logic [1:0]  Blink;
    logic        Sec_Tick;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    clock_time_core #(.TICK_DIV(4), .DEBOUNCE(3)) dut (
        .CLK(CLK),
        .RST(RST),
        .KEY_Mode_n(KEY_Mode_n),
        .KEY_Inc_n(KEY_Inc_n),
        .KEY_Dec_n(KEY_Dec_n),
        .Number_Data(Number_Data),
        .Blink(Blink),
        .Sec_Tick(Sec_Tick)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // which: 0 mode, 1 inc, 2 dec, 3 inc and dec together
    task automatic drive(input int which, input logic v);
        case (which)
            0:       KEY_Mode_n = v;
            1:       KEY_Inc_n  = v;
            2:       KEY_Dec_n  = v;
            default: begin KEY_Inc_n = v; KEY_Dec_n = v; end
        endcase
    endtask

    // Called on a falling edge; returns once the key is released and settled.
    task automatic press(input int which, input int hold);
        drive(which, 1'b0);
        repeat (hold) @(negedge CLK);
        drive(which, 1'b1);
        repeat (8) @(negedge CLK);
    endtask

    // Reset, then a Mode press timed from reset release. One tick (sec = 1)
    // lands before the state leaves RUN six edges after the key goes low.
    task automatic reset_and_enter_set_hour();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_number", Number_Data, 24'h000000);
        check("rst_blink", {22'd0, Blink}, 24'h0);
        check("rst_tick", {23'd0, Sec_Tick}, 24'h0);
        RST = 1'b0;
        KEY_Mode_n = 1'b0;
        repeat (5) @(negedge CLK);
        check("blink_before_event", {22'd0, Blink}, 24'h0);
        @(negedge CLK);
        check("blink_set_hour", {22'd0, Blink}, 24'h3);
        check("time_on_enter", Number_Data, 24'h000001);
        repeat (4) @(negedge CLK);
        KEY_Mode_n = 1'b1;
        repeat (8) @(negedge CLK);
        check("blink_hold_one_event", {22'd0, Blink}, 24'h3);
    endtask

    initial begin
        RST = 1'b1;
        KEY_Mode_n = 1'b1;
        KEY_Inc_n  = 1'b1;
        KEY_Dec_n  = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset_number", Number_Data, 24'h000000);
        check("reset_blink", {22'd0, Blink}, 24'h0);
        check("reset_sec_tick", {23'd0, Sec_Tick}, 24'h0);

        // 240 cycles of RUN -> 60 seconds.
        RST = 1'b0;
        repeat (240) begin
            @(negedge CLK);
            if (Sec_Tick === 1'b1) ticks++;
        end
        check("tick_count", 24'(ticks), 24'd60);
        check("one_minute", Number_Data, 24'h000100);
        check("run_blink", {22'd0, Blink}, 24'h0);

        // Preload 23:59:58 and exercise wrap boundaries.
        reset_and_enter_set_hour();
        press(2, 10);
        check("hour_dec_wrap", Number_Data, 24'h170001);
        press(1, 10);
        check("hour_inc_wrap", Number_Data, 24'h000001);
        press(2, 10);
        check("hour_dec_again", Number_Data, 24'h170001);
        press(0, 10);
        check("blink_set_min", {22'd0, Blink}, 24'h2);
        press(2, 10);
        check("min_dec_wrap", Number_Data, 24'h173B01);
        press(0, 10);
        check("blink_set_sec", {22'd0, Blink}, 24'h1);
        press(2, 10);
        check("sec_dec_1", Number_Data, 24'h173B00);
        press(2, 10);
        check("sec_dec_wrap", Number_Data, 24'h173B3B);
        press(2, 10);
        check("sec_dec_3", Number_Data, 24'h173B3A);

        // Bounce shorter than DEBOUNCE: low 2, high 1, low 2.
        KEY_Inc_n = 1'b0;
        repeat (2) @(negedge CLK);
        KEY_Inc_n = 1'b1;
        @(negedge CLK);
        KEY_Inc_n = 1'b0;
        repeat (2) @(negedge CLK);
        KEY_Inc_n = 1'b1;
        repeat (10) @(negedge CLK);
        check("bounce_ignored", Number_Data, 24'h173B3A);
        press(3, 10);
        check("inc_dec_cancel", Number_Data, 24'h173B3A);

        // Back to RUN: first tick after exactly TICK_DIV cycles, then midnight rollover.
        KEY_Mode_n = 1'b0;
        repeat (5) @(negedge CLK);
        check("blink_still_sec", {22'd0, Blink}, 24'h1);
        @(negedge CLK);
        check("blink_run", {22'd0, Blink}, 24'h0);
        check("no_tick_at_entry", {23'd0, Sec_Tick}, 24'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("no_early_tick", {23'd0, Sec_Tick}, 24'h0);
        end
        @(negedge CLK);
        check("first_tick", {23'd0, Sec_Tick}, 24'h1);
        check("time_235959", Number_Data, 24'h173B3B);
        KEY_Mode_n = 1'b1;
        repeat (4) @(negedge CLK);
        check("midnight_tick", {23'd0, Sec_Tick}, 24'h1);
        check("midnight", Number_Data, 24'h000000);

        press(1, 10);
        check("inc_ignored_in_run", Number_Data, 24'h000004);
        check("blink_run_after_inc", {22'd0, Blink}, 24'h0);

        // Build 12:34:56 in SET_SEC, then reset mid-edit.
        reset_and_enter_set_hour();
        for (int i = 0; i < 12; i++) press(1, 10);
        press(0, 10);
        for (int i = 0; i < 34; i++) press(1, 10);
        press(0, 10);
        for (int i = 0; i < 55; i++) press(1, 10);
        check("preset_123456", Number_Data, 24'h0C2238);
        check("preset_blink", {22'd0, Blink}, 24'h1);

        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midedit_rst_number", Number_Data, 24'h000000);
        check("midedit_rst_blink", {22'd0, Blink}, 24'h0);
        check("midedit_rst_tick", {23'd0, Sec_Tick}, 24'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("presc_restart_quiet", {23'd0, Sec_Tick}, 24'h0);
        end
        @(negedge CLK);
        check("presc_restart_tick", {23'd0, Sec_Tick}, 24'h1);
        check("presc_restart_time", Number_Data, 24'h000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
